// File: rtl/bcd_pkg.sv
// Shared decimal-datapath definitions: BCD digit constants, FSM encoding, digit check.
package bcd_pkg;

  localparam int unsigned BCD_W     = 4;
  localparam logic [3:0]  BCD_MAX   = 4'd9;
  localparam int unsigned BCD_RADIX = 10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FIN  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_FIN  = ST_FIN
  } state_e;

  // True when a 4-bit code is a legal decimal digit.
  function automatic logic bcd_digit_ok(input logic [BCD_W-1:0] x);
    return x <= BCD_MAX;
  endfunction

endpackage

// File: rtl/bcd_serial_sub_if.sv
// Request/result bundle of the digit-serial BCD subtractor.
interface bcd_serial_sub_if #(
  parameter int unsigned DIGITS = 4
);
  localparam int unsigned W = 4 * DIGITS;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] Diff;
  logic         Bout;
  logic         err;
  logic         busy;
  logic         done;

  modport master (
    output start, a, b,
    input  Diff, Bout, err, busy, done
  );

  modport slave (
    input  start, a, b,
    output Diff, Bout, err, busy, done
  );

endinterface

// File: rtl/bcd_digit_sub.sv
// One BCD digit subtraction with borrow: d = a - b - bin, wrapped into 0..9.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  logic [BCD_W-1:0] a,
  input  logic [BCD_W-1:0] b,
  input  logic             bin,
  output logic [BCD_W-1:0] d,
  output logic             bout
);

  logic [BCD_W:0] t;

  // Five-bit two's-complement difference; the top bit flags a negative digit.
  always_comb begin
    t    = {1'b0, a} - {1'b0, b} - {{BCD_W{1'b0}}, bin};
    bout = t[BCD_W];
    d    = t[BCD_W] ? BCD_W'(t + (BCD_W + 1)'(BCD_RADIX)) : t[BCD_W-1:0];
  end

endmodule

// File: rtl/bcd_serial_sub.sv
// Digit-serial packed-BCD subtractor: Diff = a - b, LSD first, one digit per clock.
// A negative result comes back in 10's complement with Bout set.
module bcd_serial_sub
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  bcd_serial_sub_if.slave bus
);

  localparam int unsigned W     = BCD_W * DIGITS;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  state_e             state;
  logic [W-1:0]       a_sr;
  logic [W-1:0]       b_sr;
  logic [W-1:0]       diff;
  logic [IDX_W-1:0]   idx;
  logic               borrow;
  logic               bout;
  logic               err;
  logic               busy;
  logic               done;

  logic [BCD_W-1:0]   d_c;
  logic               bout_c;
  logic               err_c;
  logic [W-1:0]       diff_shift_c;

  // Single digit slice, time-shared: always works on the current LSD of the shifters.
  bcd_digit_sub u_digit (
    .a    (a_sr[BCD_W-1:0]),
    .b    (b_sr[BCD_W-1:0]),
    .bin  (borrow),
    .d    (d_c),
    .bout (bout_c)
  );

  // Flag any non-decimal digit on the operands being captured.
  always_comb begin
    err_c = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (!bcd_digit_ok(bus.a[i*BCD_W +: BCD_W]) || !bcd_digit_ok(bus.b[i*BCD_W +: BCD_W])) begin
        err_c = 1'b1;
      end
    end
  end

  // New result digit enters at the MSD end so digit 0 lands in [3:0] after the last step.
  always_comb begin
    diff_shift_c = (diff >> BCD_W) | (W'(d_c) << (W - BCD_W));
  end

  // Control FSM, operand shifters, borrow chain and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      a_sr   <= '0;
      b_sr   <= '0;
      diff   <= '0;
      idx    <= '0;
      borrow <= 1'b0;
      bout   <= 1'b0;
      err    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          // The done cycle falls here, so busy only drops once IDLE is idle.
          busy <= bus.start;
          if (bus.start) begin
            a_sr   <= bus.a;
            b_sr   <= bus.b;
            borrow <= 1'b0;
            idx    <= '0;
            err    <= err_c;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          diff   <= diff_shift_c;
          borrow <= bout_c;
          a_sr   <= a_sr >> BCD_W;
          b_sr   <= b_sr >> BCD_W;
          if (idx == IDX_LAST) begin
            bout  <= bout_c;
            state <= S_FIN;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        S_FIN: begin
          done  <= 1'b1;
          state <= S_IDLE;
          if (err) begin
            diff <= '0;
            bout <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.Diff = diff;
  assign bus.Bout = bout;
  assign bus.err  = err;
  assign bus.busy = busy;
  assign bus.done = done;

endmodule

// File: tb/tb_bcd_serial_sub.sv
// Scoreboard bench for bcd_serial_sub (DIGITS=4): directed vectors, decoupled monitor.
module tb_bcd_serial_sub;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4 * DIGITS;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         err;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_serial_sub_if #(.DIGITS(DIGITS)) bus ();

  bcd_serial_sub #(.DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  function automatic void check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_done", W'(bus.done), '0);
      end else begin
        mon_e = sb.pop_front();
        check("diff",    bus.Diff,     mon_e.diff);
        check("bout",    W'(bus.Bout), W'(mon_e.bout));
        check("err",     W'(bus.err),  W'(mon_e.err));
        check("latency", W'(cyc),      W'(mon_e.cyc));
      end
    end
  end

  // Issue one request; expectation is queued once the accepting edge is known.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ed, input logic eb, input logic ee);
    exp_t e;
    @(negedge clk);
    bus.a     = av;
    bus.b     = bv;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    e.diff = ed;
    e.bout = eb;
    e.err  = ee;
    e.cyc  = cyc + int'(DIGITS) + 1;
    sb.push_back(e);
    check("busy_after_start", W'(bus.busy), W'(1));
    @(negedge clk);
    bus.start = 1'b0;
    bus.a     = 16'h5555;
    bus.b     = 16'h4444;
  endtask

  // Wait (bounded) until the monitor has consumed every expectation.
  task automatic wait_idle(input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check({tag, "_timeout"}, W'(sb.size()), '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #3;
    check("rst_diff", bus.Diff,     '0);
    check("rst_bout", W'(bus.Bout), '0);
    check("rst_err",  W'(bus.err),  '0);
    check("rst_busy", W'(bus.busy), '0);
    check("rst_done", W'(bus.done), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(16'h0042, 16'h0017, 16'h0025, 1'b0, 1'b0);
    wait_idle("op1");
    check("busy_after_done", W'(bus.busy), '0);
    run_op(16'h0017, 16'h0042, 16'h9975, 1'b1, 1'b0);
    wait_idle("op2");
    run_op(16'h1000, 16'h0001, 16'h0999, 1'b0, 1'b0);
    wait_idle("op3");
    run_op(16'h9999, 16'h9999, 16'h0000, 1'b0, 1'b0);
    wait_idle("op4");
    run_op(16'h0000, 16'h0001, 16'h9999, 1'b1, 1'b0);
    wait_idle("op5");
    run_op(16'h00A1, 16'h0001, 16'h0000, 1'b0, 1'b1);
    wait_idle("op6");
    run_op(16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0);
    wait_idle("op7");

    // Second start while busy must be dropped.
    run_op(16'h0042, 16'h0017, 16'h0025, 1'b0, 1'b0);
    @(negedge clk);
    bus.a     = 16'h0001;
    bus.b     = 16'h0001;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle("op8");
    check("busy_after_ignored", W'(bus.busy), '0);
    repeat (8) @(posedge clk);

    // Asynchronous abort mid-RUN: outputs clear at once, no done follows.
    run_op(16'h0042, 16'h0017, 16'h0025, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("abort_diff", bus.Diff,     '0);
    check("abort_bout", W'(bus.Bout), '0);
    check("abort_err",  W'(bus.err),  '0);
    check("abort_busy", W'(bus.busy), '0);
    check("abort_done", W'(bus.done), '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    run_op(16'h0003, 16'h0001, 16'h0002, 1'b0, 1'b0);
    wait_idle("op9");
    repeat (5) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
